// File: rtl/core_div_unit.sv
// core_div_unit: iterative radix-2 RV32M divider (DIV/DIVU/REM/REMU).
// Responder side of the EX multi-cycle handshake. EX holds req_i and the
// operands stable until valid_o.
//
// Ports:
//   clk_i       clock
//   rst_i       synchronous active-high reset
//   req_i       divide request from EX
//   flush_i     pipeline flush, aborts any operation in flight
//   funct3_i    4 DIV, 5 DIVU, 6 REM, 7 REMU (anything else behaves as DIVU)
//   dividend_i  rs1 operand
//   divisor_i   rs2 operand
//   result_o    registered quotient or remainder, held until the next accept
//   busy_o      high in CALC and DONE
//   valid_pc_o  strobe one cycle ahead of valid_o (PC/IF release)
//   valid_o     result strobe
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for req_i; special cases resolve here in one cycle
// CALC  | XLEN shift-subtract iterations on magnitudes
// DONE  | result_o valid, valid_o strobes, always returns to IDLE
module core_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_i,
  input  logic            flush_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o,
  output logic            valid_pc_o,
  output logic            valid_o
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_dvs;
  logic            r_is_rem;
  logic            r_neg_quo;
  logic            r_neg_rem;
  logic [XLEN-1:0] r_result;

  logic            w_signed;
  logic            w_is_rem;
  logic            w_div_zero;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_special_res;
  logic            w_dvd_neg;
  logic            w_dvs_neg;
  logic [XLEN-1:0] w_dvd_abs;
  logic [XLEN-1:0] w_dvs_abs;
  logic            w_accept;
  logic            w_last;
  logic [XLEN:0]   w_shift;
  logic            w_ge;
  logic [XLEN-1:0] w_rem_nxt;
  logic [XLEN-1:0] w_quo_nxt;
  logic [XLEN-1:0] w_final;

  // Operand decode and special-case detection (IDLE only)
  always_comb begin
    w_signed   = (funct3_i == 3'h4) || (funct3_i == 3'h6);
    w_is_rem   = (funct3_i == 3'h6) || (funct3_i == 3'h7);
    w_div_zero = (divisor_i == '0);
    w_ovf      = w_signed && (dividend_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                 (divisor_i == '1);
    w_special  = w_div_zero || w_ovf;
    // Overflow quotient is the most negative value, which equals the dividend.
    if (w_div_zero) w_special_res = w_is_rem ? dividend_i : '1;
    else            w_special_res = w_is_rem ? '0 : dividend_i;
    w_dvd_neg  = w_signed && dividend_i[XLEN-1];
    w_dvs_neg  = w_signed && divisor_i[XLEN-1];
    w_dvd_abs  = w_dvd_neg ? -dividend_i : dividend_i;
    w_dvs_abs  = w_dvs_neg ? -divisor_i : divisor_i;
    w_accept   = (r_state == S_IDLE) && req_i && !flush_i;
    w_last     = (r_state == S_CALC) && (r_cnt == CW'(XLEN-1));
  end

  // One shift-subtract step, plus sign fix-up for the final step
  always_comb begin
    w_shift   = {r_rem, r_quo[XLEN-1]};
    w_ge      = (w_shift >= {1'b0, r_dvs});
    w_rem_nxt = w_ge ? XLEN'(w_shift - {1'b0, r_dvs}) : w_shift[XLEN-1:0];
    w_quo_nxt = {r_quo[XLEN-2:0], w_ge};
    if (r_is_rem) w_final = r_neg_rem ? -w_rem_nxt : w_rem_nxt;
    else          w_final = r_neg_quo ? -w_quo_nxt : w_quo_nxt;
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_i && !flush_i) w_next = w_special ? S_DONE : S_CALC;
      end
      S_CALC: begin
        if (flush_i)     w_next = S_IDLE;
        else if (w_last) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy_o     = (r_state != S_IDLE);
    valid_o    = (r_state == S_DONE) && !flush_i && !rst_i;
    valid_pc_o = !flush_i && !rst_i &&
                 (((r_state == S_IDLE) && req_i && w_special) || w_last);
    result_o   = r_result;
  end

  // Datapath; frozen while a flush is pending in CALC
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_dvs     <= '0;
      r_is_rem  <= 1'b0;
      r_neg_quo <= 1'b0;
      r_neg_rem <= 1'b0;
      r_result  <= '0;
    end else if (w_accept) begin
      if (w_special) begin
        r_result <= w_special_res;
      end else begin
        r_quo     <= w_dvd_abs;
        r_dvs     <= w_dvs_abs;
        r_rem     <= '0;
        r_cnt     <= '0;
        r_is_rem  <= w_is_rem;
        r_neg_quo <= w_dvd_neg ^ w_dvs_neg;
        r_neg_rem <= w_dvd_neg;
      end
    end else if ((r_state == S_CALC) && !flush_i) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) r_result <= w_final;
    end
  end

endmodule
